tcbm_link_ctrl: RTL and testbench



---
 rtl/tcbm_link_ctrl_pkg.sv | 25 ++
 rtl/tcbm_sync.sv | 25 ++
 rtl/tcbm_link_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_tcbm_link_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/tcbm_link_ctrl_pkg.sv
// Shared definitions for the TCBM drive-side link controller: FSM state encodings,
// DAV/ACK active levels and transfer direction codes.
package tcbm_link_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RX_SETTLE = 3'd1,
    ST_RX_HOLD   = 3'd2,
    ST_TX_DRIVE  = 3'd3,
    ST_WAIT_REL  = 3'd4
  } state_t;

  localparam logic DAV_ACTIVE = 1'b0;
  localparam logic DAV_IDLE   = 1'b1;
  localparam logic ACK_ACTIVE = 1'b0;
  localparam logic ACK_IDLE   = 1'b1;
  localparam logic DIR_RX     = 1'b0;
  localparam logic DIR_TX     = 1'b1;

  // The handshake holds ACK low from the byte hand-off until DAV is released.
  function automatic logic holds_ack(input state_t st);
    return (st == ST_TX_DRIVE) || (st == ST_WAIT_REL);
  endfunction

endpackage

// File: rtl/tcbm_sync.sv
// Flop-chain synchronizer for the asynchronous, active-low DAV line; resets to the
// idle (high) level so the controller never sees a spurious request after reset.
module tcbm_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift the asynchronous input through the chain.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_r <= {STAGES{1'b1}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/tcbm_link_ctrl.sv
// TCBM drive-side protocol engine: 4-phase DAV/ACK handshake with a valid/ready byte port.
// Optional handshake watchdog is enabled with `define TCBM_TIMEOUT_EN.
module tcbm_link_ctrl
  import tcbm_link_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int SETTLE_CYCLES  = 3,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       dav_i,
  output logic       ack_o,
  input  logic [7:0] bus_i,
  output logic [7:0] bus_o,
  output logic       bus_oe,
  output logic [1:0] st_o,
  input  logic       dir,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic [1:0] tx_status,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       timeout_err
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  if ((SYNC_STAGES < 2) || (SETTLE_CYCLES < 1) || (TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_param_check
    $error("tcbm_link_ctrl: parameter out of range");
  end

  logic                dav_s;
  logic                timeout_hit_s;
  state_t              state_r, state_nxt_s;
  logic [SETTLE_W-1:0] settle_cnt_r, settle_cnt_nxt_s;
  logic                ack_r, ack_nxt_s;
  logic [7:0]          bus_o_r, bus_o_nxt_s;
  logic                bus_oe_r, bus_oe_nxt_s;
  logic [1:0]          st_r, st_nxt_s;
  logic [7:0]          rx_data_r, rx_data_nxt_s;
  logic                rx_valid_r, rx_valid_nxt_s;
  logic                tx_ready_r, tx_ready_nxt_s;
  logic                busy_r, busy_nxt_s;
  logic                timeout_err_r, timeout_err_nxt_s;

  tcbm_sync #(.STAGES(SYNC_STAGES)) u_dav_sync (
    .clock (clock),
    .reset (reset),
    .d     (dav_i),
    .q     (dav_s)
  );

`ifdef TCBM_TIMEOUT_EN
  logic [15:0] wait_cnt_r;

  // Watchdog counts cycles spent waiting on the consumer or on DAV release.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt_r <= 16'd0;
    end else if (state_nxt_s != state_r) begin
      wait_cnt_r <= 16'd0;
    end else if ((state_r == ST_RX_HOLD) || (state_r == ST_WAIT_REL)) begin
      wait_cnt_r <= wait_cnt_r + 16'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  assign timeout_hit_s = ((state_r == ST_RX_HOLD) || (state_r == ST_WAIT_REL)) &&
                         (wait_cnt_r == 16'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit_s = 1'b0;
`endif

  // State register plus settle counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      settle_cnt_r <= {SETTLE_W{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      settle_cnt_r <= settle_cnt_nxt_s;
    end
  end

  // Next-state logic; the settle counter is loaded with SETTLE_CYCLES-1 so the byte
  // is latched on the SETTLE_CYCLES-th edge spent in RX_SETTLE.
  always_comb begin
    state_nxt_s      = state_r;
    settle_cnt_nxt_s = settle_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (dav_s == DAV_ACTIVE) begin
          if (dir == DIR_RX) begin
            state_nxt_s      = ST_RX_SETTLE;
            settle_cnt_nxt_s = SETTLE_W'(SETTLE_CYCLES - 1);
          end else if (tx_valid) begin
            state_nxt_s = ST_TX_DRIVE;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RX_SETTLE: begin
        if (dav_s == DAV_IDLE) begin
          state_nxt_s = ST_IDLE;
        end else if (settle_cnt_r == {SETTLE_W{1'b0}}) begin
          state_nxt_s = ST_RX_HOLD;
        end else begin
          settle_cnt_nxt_s = settle_cnt_r - SETTLE_W'(1);
        end
      end
      ST_RX_HOLD: begin
        if (timeout_hit_s) begin
          state_nxt_s = ST_IDLE;
        end else if (rx_ready) begin
          state_nxt_s = ST_WAIT_REL;
        end else begin
          state_nxt_s = ST_RX_HOLD;
        end
      end
      ST_TX_DRIVE: begin
        state_nxt_s = ST_WAIT_REL;
      end
      ST_WAIT_REL: begin
        if (timeout_hit_s || (dav_s == DAV_IDLE)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_REL;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs, derived from the transition being taken.
  always_comb begin
    ack_nxt_s         = holds_ack(state_nxt_s) ? ACK_ACTIVE : ack_r;
    bus_o_nxt_s       = bus_o_r;
    bus_oe_nxt_s      = bus_oe_r;
    st_nxt_s          = st_r;
    rx_data_nxt_s     = rx_data_r;
    rx_valid_nxt_s    = rx_valid_r;
    tx_ready_nxt_s    = 1'b0;
    timeout_err_nxt_s = 1'b0;
    busy_nxt_s        = (state_nxt_s != ST_IDLE);
    case (state_r)
      ST_IDLE: begin
        if (state_nxt_s == ST_TX_DRIVE) begin
          bus_o_nxt_s    = tx_data;
          st_nxt_s       = tx_status;
          bus_oe_nxt_s   = 1'b1;
          tx_ready_nxt_s = 1'b1;
        end else begin
          ack_nxt_s = ACK_IDLE;
        end
      end
      ST_RX_SETTLE: begin
        if (state_nxt_s == ST_RX_HOLD) begin
          rx_data_nxt_s  = bus_i;
          rx_valid_nxt_s = 1'b1;
        end else begin
          rx_valid_nxt_s = rx_valid_r;
        end
      end
      ST_RX_HOLD: begin
        if (timeout_hit_s) begin
          ack_nxt_s         = ACK_IDLE;
          bus_oe_nxt_s      = 1'b0;
          rx_valid_nxt_s    = 1'b0;
          timeout_err_nxt_s = 1'b1;
        end else if (rx_ready) begin
          rx_valid_nxt_s = 1'b0;
        end else begin
          rx_valid_nxt_s = 1'b1;
        end
      end
      ST_TX_DRIVE: begin
        bus_oe_nxt_s = 1'b1;
      end
      ST_WAIT_REL: begin
        if (state_nxt_s == ST_IDLE) begin
          ack_nxt_s         = ACK_IDLE;
          bus_oe_nxt_s      = 1'b0;
          rx_valid_nxt_s    = 1'b0;
          timeout_err_nxt_s = timeout_hit_s;
        end else begin
          ack_nxt_s = ACK_ACTIVE;
        end
      end
      default: begin
        ack_nxt_s    = ACK_IDLE;
        bus_oe_nxt_s = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      ack_r         <= ACK_IDLE;
      bus_o_r       <= 8'h00;
      bus_oe_r      <= 1'b0;
      st_r          <= 2'b00;
      rx_data_r     <= 8'h00;
      rx_valid_r    <= 1'b0;
      tx_ready_r    <= 1'b0;
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      ack_r         <= ack_nxt_s;
      bus_o_r       <= bus_o_nxt_s;
      bus_oe_r      <= bus_oe_nxt_s;
      st_r          <= st_nxt_s;
      rx_data_r     <= rx_data_nxt_s;
      rx_valid_r    <= rx_valid_nxt_s;
      tx_ready_r    <= tx_ready_nxt_s;
      busy_r        <= busy_nxt_s;
      timeout_err_r <= timeout_err_nxt_s;
    end
  end

  assign ack_o       = ack_r;
  assign bus_o       = bus_o_r;
  assign bus_oe      = bus_oe_r;
  assign st_o        = st_r;
  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign tx_ready    = tx_ready_r;
  assign busy        = busy_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_tcbm_link_ctrl.sv
// Directed self-checking bench for tcbm_link_ctrl (SYNC_STAGES=2, SETTLE_CYCLES=3,
// TIMEOUT_CYCLES=100); the watchdog section follows `TCBM_TIMEOUT_EN.
module tb_tcbm_link_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       dav_i;
  logic       ack_o;
  logic [7:0] bus_i;
  logic [7:0] bus_o;
  logic       bus_oe;
  logic [1:0] st_o;
  logic       dir;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic [1:0] tx_status;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       timeout_err;

  int n_asserts = 0;
  int n_fail    = 0;

  tcbm_link_ctrl #(
    .SYNC_STAGES   (2),
    .SETTLE_CYCLES (3),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .dav_i      (dav_i),
    .ack_o      (ack_o),
    .bus_i      (bus_i),
    .bus_o      (bus_o),
    .bus_oe     (bus_oe),
    .st_o       (st_o),
    .dir        (dir),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_status  (tx_status),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; dav_i = 1'b1; bus_i = 8'h00; dir = 1'b0; rx_ready = 1'b0;
    tx_data = 8'h00; tx_status = 2'b00; tx_valid = 1'b0;
    tick(3);
    chk("rst_ack", {7'd0, ack_o}, 8'h01);
    chk("rst_bus_oe", {7'd0, bus_oe}, 8'h00);
    chk("rst_bus_o", bus_o, 8'h00);
    chk("rst_st", {6'd0, st_o}, 8'h00);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", {7'd0, rx_valid}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_tx_ready", {7'd0, tx_ready}, 8'h00);
    reset = 1'b0;
    tick(2);

    // Receive: byte visible after 2+3+1 edges, ACK one edge after acceptance.
    dir = 1'b0; bus_i = 8'h81; rx_ready = 1'b1; dav_i = 1'b0;
    tick(5);
    chk("rx_valid_early", {7'd0, rx_valid}, 8'h00);
    tick(1);
    chk("rx_valid_c6", {7'd0, rx_valid}, 8'h01);
    chk("rx_data_c6", rx_data, 8'h81);
    chk("rx_ack_c6", {7'd0, ack_o}, 8'h01);
    chk("rx_busy", {7'd0, busy}, 8'h01);
    tick(1);
    chk("rx_ack_low", {7'd0, ack_o}, 8'h00);
    chk("rx_valid_clr", {7'd0, rx_valid}, 8'h00);
    dav_i = 1'b1;
    tick(2);
    chk("rx_ack_hold", {7'd0, ack_o}, 8'h00);
    tick(1);
    chk("rx_ack_rel", {7'd0, ack_o}, 8'h01);
    chk("rx_busy_end", {7'd0, busy}, 8'h00);

    // Backpressure: byte held and ACK withheld while consumer stalls.
    rx_ready = 1'b0; bus_i = 8'h3C; dav_i = 1'b0;
    tick(6);
    chk("bp_valid", {7'd0, rx_valid}, 8'h01);
    bus_i = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("bp_ack_high", {7'd0, ack_o}, 8'h01);
      chk("bp_data_stable", rx_data, 8'h3C);
    end
    rx_ready = 1'b1;
    tick(1);
    chk("bp_ack_low", {7'd0, ack_o}, 8'h00);
    dav_i = 1'b1;
    tick(3);
    chk("bp_ack_rel", {7'd0, ack_o}, 8'h01);
    chk("bp_data_kept", rx_data, 8'h3C);

    // Send: drive byte/status, single tx_ready pulse, release on DAV high.
    dir = 1'b1; tx_data = 8'h5A; tx_status = 2'b10; tx_valid = 1'b1; dav_i = 1'b0;
    tick(2);
    chk("tx_ready_pre", {7'd0, tx_ready}, 8'h00);
    chk("tx_oe_pre", {7'd0, bus_oe}, 8'h00);
    tick(1);
    chk("tx_ready_pulse", {7'd0, tx_ready}, 8'h01);
    chk("tx_bus_o", bus_o, 8'h5A);
    chk("tx_st", {6'd0, st_o}, 8'h02);
    chk("tx_oe", {7'd0, bus_oe}, 8'h01);
    chk("tx_ack", {7'd0, ack_o}, 8'h00);
    tx_valid = 1'b0; tx_data = 8'h00; tx_status = 2'b00;
    tick(1);
    chk("tx_ready_once", {7'd0, tx_ready}, 8'h00);
    tick(3);
    chk("tx_bus_hold", bus_o, 8'h5A);
    chk("tx_oe_hold", {7'd0, bus_oe}, 8'h01);
    chk("tx_ack_hold", {7'd0, ack_o}, 8'h00);
    dav_i = 1'b1;
    tick(2);
    chk("tx_oe_still", {7'd0, bus_oe}, 8'h01);
    tick(1);
    chk("tx_oe_rel", {7'd0, bus_oe}, 8'h00);
    chk("tx_ack_rel", {7'd0, ack_o}, 8'h01);
    chk("tx_st_keep", {6'd0, st_o}, 8'h02);
    chk("tx_busy_end", {7'd0, busy}, 8'h00);

    // Send requested with no byte available: host is left waiting.
    dir = 1'b1; tx_valid = 1'b0; dav_i = 1'b0;
    tick(10);
    chk("txw_ack", {7'd0, ack_o}, 8'h01);
    chk("txw_busy", {7'd0, busy}, 8'h00);
    tx_data = 8'hA5; tx_status = 2'b01; tx_valid = 1'b1;
    tick(1);
    chk("txw_ready", {7'd0, tx_ready}, 8'h01);
    chk("txw_bus_o", bus_o, 8'hA5);
    tx_valid = 1'b0; dir = 1'b0;
    tick(1);

    // Reset in WAIT_REL of a send.
    reset = 1'b1;
    tick(1);
    chk("mrst_ack", {7'd0, ack_o}, 8'h01);
    chk("mrst_oe", {7'd0, bus_oe}, 8'h00);
    chk("mrst_busy", {7'd0, busy}, 8'h00);
    chk("mrst_rx_valid", {7'd0, rx_valid}, 8'h00);
    chk("mrst_bus_o", bus_o, 8'h00);
    reset = 1'b0; dav_i = 1'b1;
    tick(3);

    // DAV glitch: one synchronized low cycle enters settle, then aborts.
    dir = 1'b0; bus_i = 8'h77; rx_ready = 1'b1; dav_i = 1'b0;
    tick(1);
    dav_i = 1'b1;
    tick(2);
    chk("gl_busy_settle", {7'd0, busy}, 8'h01);
    tick(1);
    chk("gl_busy_abort", {7'd0, busy}, 8'h00);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("gl_no_valid", {7'd0, rx_valid}, 8'h00);
      chk("gl_ack_high", {7'd0, ack_o}, 8'h01);
    end

    // Boundary: DAV low exactly SETTLE_CYCLES cycles is still too short to latch.
    dav_i = 1'b0;
    tick(3);
    dav_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("bd_no_valid", {7'd0, rx_valid}, 8'h00);
    end
    chk("bd_rx_data", rx_data, 8'h00);

    // DAV held low after ACK on a send.
    dir = 1'b1; tx_data = 8'hC3; tx_status = 2'b11; tx_valid = 1'b1; dav_i = 1'b0;
    tick(3);
    chk("to_ack_low", {7'd0, ack_o}, 8'h00);
    tx_valid = 1'b0;
    tick(1);
`ifdef TCBM_TIMEOUT_EN
    for (int i = 0; i < 99; i++) begin
      tick(1);
      chk("to_wait_ack", {7'd0, ack_o}, 8'h00);
      chk("to_wait_err", {7'd0, timeout_err}, 8'h00);
    end
    tick(1);
    chk("to_err_pulse", {7'd0, timeout_err}, 8'h01);
    chk("to_ack_rel", {7'd0, ack_o}, 8'h01);
    chk("to_oe_rel", {7'd0, bus_oe}, 8'h00);
    chk("to_busy", {7'd0, busy}, 8'h00);
    dir = 1'b0;
    tick(1);
    chk("to_err_once", {7'd0, timeout_err}, 8'h00);
`else
    for (int i = 0; i < 150; i++) begin
      tick(1);
      chk("nto_ack", {7'd0, ack_o}, 8'h00);
      chk("nto_err", {7'd0, timeout_err}, 8'h00);
    end
    chk("nto_busy", {7'd0, busy}, 8'h01);
`endif
    dav_i = 1'b1;
    tick(4);
    chk("end_ack", {7'd0, ack_o}, 8'h01);
    chk("end_busy", {7'd0, busy}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
